// File: rtl/jk_pkg.sv
// Shared mode encodings for the JK register/counter bank.
package jk_pkg;

  localparam logic [1:0] MODE_JK   = 2'b00;
  localparam logic [1:0] MODE_LOAD = 2'b01;
  localparam logic [1:0] MODE_UP   = 2'b10;
  localparam logic [1:0] MODE_DOWN = 2'b11;

endpackage

// File: rtl/jk_cell.sv
// Single JK flip-flop with asynchronous active-high reset to RST_BIT.
module jk_cell #(
  parameter logic RST_BIT = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic j,
  input  logic k,
  output logic q
);

  logic q_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_q <= RST_BIT;
    end else begin
      case ({j, k})
        2'b00:   q_q <= q_q;
        2'b01:   q_q <= 1'b0;
        2'b10:   q_q <= 1'b1;
        default: q_q <= ~q_q;
      endcase
    end
  end

  assign q = q_q;

endmodule

// File: rtl/jk_reg_counter.sv
// WIDTH-bit bank of JK cells steered per mode: per-bit JK, parallel load, up/down count,
// with terminal-count and change-detect status.
module jk_reg_counter
  import jk_pkg::*;
#(
  parameter int unsigned      WIDTH    = 8,
  parameter logic [WIDTH-1:0] RST_VAL  = '0,
  parameter bit               SATURATE = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] j,
  input  logic [WIDTH-1:0] k,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic             tc,
  output logic             changed
);

  logic [WIDTH-1:0] up_te;
  logic [WIDTH-1:0] dn_te;
  logic [WIDTH-1:0] cell_j;
  logic [WIDTH-1:0] cell_k;
  logic [WIDTH-1:0] q_next;
  logic             all_ones;
  logic             all_zero;
  logic             sat_hold;
  logic             changed_d;
  logic             changed_q;

  // Classic synchronous JK counter: bit i toggles when all lower bits are 1 (up) / 0 (down).
  assign up_te[0] = 1'b1;
  assign dn_te[0] = 1'b1;
  for (genvar i = 1; i < WIDTH; i++) begin : g_te
    assign up_te[i] = &q[i-1:0];
    assign dn_te[i] = ~|q[i-1:0];
  end

  assign all_ones = &q;
  assign all_zero = ~|q;
  assign sat_hold = SATURATE && (((mode == MODE_UP) && all_ones) ||
                                 ((mode == MODE_DOWN) && all_zero));

  // Unused data inputs never reach the cells, so X there cannot leak into q.
  always_comb begin
    cell_j = '0;
    cell_k = '0;
    if (en) begin
      case (mode)
        MODE_JK: begin
          cell_j = j;
          cell_k = k;
        end
        MODE_LOAD: begin
          cell_j = d;
          cell_k = ~d;
        end
        MODE_UP: begin
          if (!sat_hold) begin
            cell_j = up_te;
            cell_k = up_te;
          end
        end
        default: begin
          if (!sat_hold) begin
            cell_j = dn_te;
            cell_k = dn_te;
          end
        end
      endcase
    end
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    jk_cell #(
      .RST_BIT(RST_VAL[i])
    ) u_cell (
      .clk(clk),
      .rst(rst),
      .j  (cell_j[i]),
      .k  (cell_k[i]),
      .q  (q[i])
    );
  end

  assign q_next    = (cell_j & ~q) | (~cell_k & q);
  assign changed_d = en & (q_next != q);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      changed_q <= 1'b0;
    end else begin
      changed_q <= changed_d;
    end
  end

  assign changed = changed_q;
  assign tc = en & (((mode == MODE_UP) & all_ones) | ((mode == MODE_DOWN) & all_zero));

endmodule

// File: tb/tb_jk_reg_counter.sv
// Directed bench for jk_reg_counter: a wrapping and a saturating instance share one stimulus.
module tb_jk_reg_counter;

  localparam logic [1:0] MJK = 2'b00;
  localparam logic [1:0] MLD = 2'b01;
  localparam logic [1:0] MUP = 2'b10;
  localparam logic [1:0] MDN = 2'b11;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       en = 1'b0;
  logic [1:0] mode = MJK;
  logic [7:0] j = '0;
  logic [7:0] k = '0;
  logic [7:0] d = '0;
  logic [7:0] qw, qs;
  logic       tcw, tcs, chw, chs;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  jk_reg_counter #(.WIDTH(8), .RST_VAL(8'hA5), .SATURATE(1'b0)) dut_wrap (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .j(j), .k(k), .d(d),
    .q(qw), .tc(tcw), .changed(chw)
  );

  jk_reg_counter #(.WIDTH(8), .RST_VAL(8'hA5), .SATURATE(1'b1)) dut_sat (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .j(j), .k(k), .d(d),
    .q(qs), .tc(tcs), .changed(chs)
  );

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [7:0] v);
    en = 1'b1; mode = MLD; d = v;
    tick();
  endtask

  initial begin
    // Reset from power-up
    #2 rst = 1'b1;
    #1;
    chk("rst_q_wrap", qw, 8'hA5);
    chk("rst_q_sat", qs, 8'hA5);
    chk("rst_changed", {7'b0, chw}, 8'h00);
    @(negedge clk);
    rst = 1'b0;
    tick();
    chk("idle_q", qw, 8'hA5);
    chk("idle_tc", {7'b0, tcw}, 8'h00);

    // 1: async reset mid-count
    load(8'h10);
    mode = MUP;
    tick();
    chk("cnt_before_rst", qw, 8'h11);
    tick();
    chk("cnt_before_rst2", qw, 8'h12);
    #1 rst = 1'b1;
    #1;
    chk("midrst_q_wrap", qw, 8'hA5);
    chk("midrst_q_sat", qs, 8'hA5);
    chk("midrst_changed", {6'b0, chw, chs}, 8'h00);
    #1 rst = 1'b0;

    // 2: JK table
    load(8'h0F);
    chk("load_0f_changed", {7'b0, chw}, 8'h01);
    mode = MJK; j = 8'hF0; k = 8'h3C;
    tick();
    chk("jk_q", qw, 8'hF3);
    chk("jk_changed", {7'b0, chw}, 8'h01);
    j = 8'h00; k = 8'h00;
    tick();
    chk("jk_hold_q", qw, 8'hF3);
    chk("jk_hold_changed", {7'b0, chw}, 8'h00);

    // 3: UP wrap vs saturate; j/k garbage must be ignored
    load(8'hFE);
    mode = MUP; j = 8'hFF; k = 8'h00; d = 8'h55;
    tick();
    chk("up1_q_wrap", qw, 8'hFF);
    chk("up1_tc_wrap", {7'b0, tcw}, 8'h01);
    chk("up1_changed_wrap", {7'b0, chw}, 8'h01);
    chk("up1_q_sat", qs, 8'hFF);
    tick();
    chk("up2_q_wrap", qw, 8'h00);
    chk("up2_tc_wrap", {7'b0, tcw}, 8'h00);
    chk("up2_changed_wrap", {7'b0, chw}, 8'h01);
    chk("up2_q_sat", qs, 8'hFF);
    chk("up2_tc_sat", {7'b0, tcs}, 8'h01);
    chk("up2_changed_sat", {7'b0, chs}, 8'h00);
    tick();
    chk("up3_q_wrap", qw, 8'h01);
    chk("up3_changed_wrap", {7'b0, chw}, 8'h01);
    chk("up3_q_sat", qs, 8'hFF);
    j = 8'h00;

    // 4: DOWN saturate vs wrap
    load(8'h01);
    mode = MDN;
    tick();
    chk("dn1_q_sat", qs, 8'h00);
    chk("dn1_changed_sat", {7'b0, chs}, 8'h01);
    chk("dn1_tc_sat", {7'b0, tcs}, 8'h01);
    chk("dn1_q_wrap", qw, 8'h00);
    tick();
    chk("dn2_q_sat", qs, 8'h00);
    chk("dn2_tc_sat", {7'b0, tcs}, 8'h01);
    chk("dn2_changed_sat", {7'b0, chs}, 8'h00);
    chk("dn2_q_wrap", qw, 8'hFF);
    chk("dn2_tc_wrap", {7'b0, tcw}, 8'h00);
    tick();
    chk("dn3_q_sat", qs, 8'h00);
    chk("dn3_q_wrap", qw, 8'hFE);

    // 5: enable gating
    load(8'h10);
    mode = MUP; en = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("engate_q", qw, 8'h10);
      chk("engate_changed", {7'b0, chw}, 8'h00);
      chk("engate_tc", {7'b0, tcw}, 8'h00);
    end
    en = 1'b1;
    tick();
    chk("en_resume_q", qw, 8'h11);
    chk("en_resume_changed", {7'b0, chw}, 8'h01);

    // 6: mode switch without dead cycles
    load(8'h7F);
    mode = MUP;
    tick();
    chk("sw_up_q", qw, 8'h80);
    mode = MDN;
    tick();
    chk("sw_dn_q", qw, 8'h7F);
    mode = MLD; d = 8'h7F;
    tick();
    chk("sw_ld_q", qw, 8'h7F);
    chk("sw_ld_changed", {7'b0, chw}, 8'h00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
